// File: rtl/display_timing_pkg.sv
// Shared types and default 640x480@60 timing for the raster timing generator.
package display_timing_pkg;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} axis_state_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Counter width for an axis of the given total length (at least 1 bit).
  function automatic int unsigned axis_width(input int unsigned total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/axis_timing.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK segment FSM.
module axis_timing
  import display_timing_pkg::*;
#(
  parameter int unsigned Active = DEF_H_ACTIVE,
  parameter int unsigned Fp     = DEF_H_FP,
  parameter int unsigned Sync   = DEF_H_SYNC,
  parameter int unsigned Bp     = DEF_H_BP,
  localparam int unsigned Total = Active + Fp + Sync + Bp,
  localparam int unsigned W     = axis_width(Total)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance,
  output logic [W-1:0] count,
  output axis_state_t  state,
  output logic         last,
  output logic         wrap
);

  if (Active < 1 || Fp < 1 || Sync < 1 || Bp < 1) begin : g_bad_params
    $fatal(1, "axis_timing: every segment length must be at least 1");
  end

  localparam logic [W-1:0] ActEnd   = W'(Active - 1);
  localparam logic [W-1:0] FrontEnd = W'(Active + Fp - 1);
  localparam logic [W-1:0] SyncEnd  = W'(Active + Fp + Sync - 1);
  localparam logic [W-1:0] BackEnd  = W'(Total - 1);

  logic [W-1:0] r_count;
  axis_state_t  r_state;
  axis_state_t  w_state_d;
  logic [W-1:0] w_seg_end;
  logic         w_last;
  logic         w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_state <= ACTIVE;
    end else if (advance) begin
      r_count <= w_wrap ? '0 : r_count + 1'b1;
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (w_last) begin
      unique case (r_state)
        ACTIVE:  w_state_d = FRONT;
        FRONT:   w_state_d = SYNC;
        SYNC:    w_state_d = BACK;
        BACK:    w_state_d = ACTIVE;
        default: w_state_d = ACTIVE;
      endcase
    end
  end

  always_comb begin
    w_seg_end = BackEnd;
    unique case (r_state)
      ACTIVE:  w_seg_end = ActEnd;
      FRONT:   w_seg_end = FrontEnd;
      SYNC:    w_seg_end = SyncEnd;
      BACK:    w_seg_end = BackEnd;
      default: w_seg_end = BackEnd;
    endcase
    w_last = (r_count == w_seg_end);
    w_wrap = w_last && (r_state == BACK);
  end

  assign count = r_count;
  assign state = r_state;
  assign last  = w_last;
  assign wrap  = w_wrap;

endmodule

// File: rtl/display_timing_ctrl.sv
// Raster timing generator: two axis counters and the registered sync/active/strobe decode.
module display_timing_ctrl
  import display_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b0,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW      = axis_width(H_TOTAL),
  localparam int unsigned YW      = axis_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  logic [XW-1:0] w_h;
  logic [YW-1:0] w_v;
  axis_state_t   w_h_state;
  axis_state_t   w_v_state;
  logic          w_h_last;
  logic          w_h_wrap;
  logic          w_v_last;
  logic          w_v_wrap;
  logic          w_unused;

  logic          r_hsync;
  logic          r_vsync;
  logic          r_active;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_line_start;
  logic          r_frame_start;

  axis_timing #(
    .Active (H_ACTIVE),
    .Fp     (H_FP),
    .Sync   (H_SYNC),
    .Bp     (H_BP)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (enable),
    .count   (w_h),
    .state   (w_h_state),
    .last    (w_h_last),
    .wrap    (w_h_wrap)
  );

  // Vertical axis steps once per completed line.
  axis_timing #(
    .Active (V_ACTIVE),
    .Fp     (V_FP),
    .Sync   (V_SYNC),
    .Bp     (V_BP)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (enable && w_h_wrap),
    .count   (w_v),
    .state   (w_v_state),
    .last    (w_v_last),
    .wrap    (w_v_wrap)
  );

  assign w_unused = ^{w_h_last, w_v_last, w_v_wrap};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_active      <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (enable) begin
      r_hsync       <= (w_h_state == SYNC) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= (w_v_state == SYNC) ? SYNC_POL : ~SYNC_POL;
      r_active      <= (w_h_state == ACTIVE) && (w_v_state == ACTIVE);
      r_x           <= w_h;
      r_y           <= w_v;
      r_line_start  <= (w_h == '0);
      r_frame_start <= (w_h == '0) && (w_v == '0);
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign active      = r_active;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_timing_ctrl.sv
// Directed bench: small 8x6 raster instance plus a default 800x525 instance.
module tb_display_timing_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;

  logic       hs, vs, act, ls, fs;
  logic [2:0] x, y;
  logic       hs2, vs2, act2, ls2, fs2;
  logic [9:0] x2, y2;

  int checks   = 0;
  int failures = 0;

  // {hsync, vsync, active, x, y, line_start, frame_start}
  localparam logic [10:0] RST_SMALL = {1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
  localparam logic [24:0] RST_DEF   = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  display_timing_ctrl #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .SYNC_POL (1'b0)
  ) u_dut_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .hsync       (hs),
    .vsync       (vs),
    .active      (act),
    .x           (x),
    .y           (y),
    .line_start  (ls),
    .frame_start (fs)
  );

  display_timing_ctrl u_dut_def (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .hsync       (hs2),
    .vsync       (vs2),
    .active      (act2),
    .x           (x2),
    .y           (y2),
    .line_start  (ls2),
    .frame_start (fs2)
  );

  function automatic logic [10:0] obs_small();
    return {hs, vs, act, x, y, ls, fs};
  endfunction

  function automatic logic [24:0] obs_def();
    return {hs2, vs2, act2, x2, y2, ls2, fs2};
  endfunction

  // Expected small-config outputs after the edge that decodes raster position p.
  // Line: h 0-3 visible, 4 front, 5-6 sync, 7 back. Frame: v 0-2 visible, 3 front, 4 sync, 5 back.
  function automatic logic [10:0] exp_small(input int p);
    int h;
    int v;
    h = p % 8;
    v = (p / 8) % 6;
    return {!(h == 5 || h == 6), !(v == 4), (h < 4) && (v < 3), 3'(h), 3'(v),
            h == 0, (h == 0) && (v == 0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (2) step();
    checks++;
    if (obs_small() !== RST_SMALL) begin
      failures++;
      $display("FAIL reset_small: got %b want %b", obs_small(), RST_SMALL);
    end
    checks++;
    if (obs_def() !== RST_DEF) begin
      failures++;
      $display("FAIL reset_default: got %b want %b", obs_def(), RST_DEF);
    end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (obs_small() !== RST_SMALL) begin
      failures++;
      $display("FAIL reset_hold_disabled: got %b want %b", obs_small(), RST_SMALL);
    end
  endtask

  task automatic test_first_line();
    logic [7:0] act_tab;
    logic [7:0] hs_tab;
    act_tab = 8'b0000_1111;
    hs_tab  = 8'b1001_1111;
    enable  = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      checks++;
      if (act !== act_tab[e]) begin
        failures++;
        $display("FAIL first_line_active[%0d]: got %b want %b", e + 1, act, act_tab[e]);
      end
      checks++;
      if (hs !== hs_tab[e]) begin
        failures++;
        $display("FAIL first_line_hsync[%0d]: got %b want %b", e + 1, hs, hs_tab[e]);
      end
      checks++;
      if ({x, y, ls, fs} !== {3'(e), 3'd0, e == 0, e == 0}) begin
        failures++;
        $display("FAIL first_line_pos[%0d]: got x=%0d y=%0d ls=%b fs=%b want x=%0d y=0",
                 e + 1, x, y, ls, fs, e);
      end
    end
  endtask

  task automatic test_frames();
    int fs_cnt;
    int ls_cnt;
    fs_cnt = 0;
    ls_cnt = 0;
    for (int p = 8; p < 8 + 3 * 48; p++) begin
      step();
      checks++;
      if (obs_small() !== exp_small(p)) begin
        failures++;
        $display("FAIL frames_pos%0d: got %b want %b", p, obs_small(), exp_small(p));
      end
      if (fs === 1'b1) fs_cnt++;
      if (ls === 1'b1) ls_cnt++;
    end
    checks++;
    if (fs_cnt != 3) begin
      failures++;
      $display("FAIL frames_fs_count: got %0d want 3", fs_cnt);
    end
    checks++;
    if (ls_cnt != 18) begin
      failures++;
      $display("FAIL frames_ls_count: got %0d want 18", ls_cnt);
    end
    enable = 1'b0;
  endtask

  task automatic test_enable_toggle();
    logic [10:0] expv;
    logic [10:0] prev;
    logic        fs_prev;
    int          p;
    int          rise[$];
    do_reset();
    prev    = RST_SMALL;
    fs_prev = 1'b0;
    p       = 0;
    for (int n = 0; n < 200; n++) begin
      enable = (n % 2 == 0);
      step();
      if (enable) begin
        expv = exp_small(p);
        p++;
      end else begin
        expv = prev;
      end
      checks++;
      if (obs_small() !== expv) begin
        failures++;
        $display("FAIL toggle_clk%0d: got %b want %b", n, obs_small(), expv);
      end
      prev = expv;
      if (fs === 1'b1 && fs_prev !== 1'b1) rise.push_back(n);
      fs_prev = fs;
    end
    enable = 1'b0;
    checks++;
    if (rise.size() < 2) begin
      failures++;
      $display("FAIL toggle_frame_period: got %0d frame starts want 2", rise.size());
    end else if (rise[1] - rise[0] != 96) begin
      failures++;
      $display("FAIL toggle_frame_period: got %0d clk want 96", rise[1] - rise[0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1;
    repeat (19) step();
    checks++;
    if (obs_small() !== exp_small(18)) begin
      failures++;
      $display("FAIL async_pre: got %b want %b", obs_small(), exp_small(18));
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_small() !== RST_SMALL) begin
      failures++;
      $display("FAIL async_immediate: got %b want %b", obs_small(), RST_SMALL);
    end
    step();
    checks++;
    if (obs_small() !== RST_SMALL) begin
      failures++;
      $display("FAIL async_held: got %b want %b", obs_small(), RST_SMALL);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (obs_small() !== exp_small(0)) begin
      failures++;
      $display("FAIL async_first_edge: got %b want %b", obs_small(), exp_small(0));
    end
    step();
    checks++;
    if (obs_small() !== exp_small(1)) begin
      failures++;
      $display("FAIL async_second_edge: got %b want %b", obs_small(), exp_small(1));
    end
    enable = 1'b0;
  endtask

  task automatic test_default();
    logic [24:0] expv;
    int          h;
    int          v;
    do_reset();
    enable = 1'b1;
    for (int p = 0; p < 1600; p++) begin
      step();
      h    = p % 800;
      v    = p / 800;
      expv = {!(h >= 656 && h <= 751), 1'b1, h < 640, 10'(h), 10'(v), h == 0, p == 0};
      checks++;
      if (obs_def() !== expv) begin
        failures++;
        $display("FAIL default_pos%0d: got %b want %b", p, obs_def(), expv);
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    test_reset();
    test_first_line();
    test_frames();
    test_enable_toggle();
    test_async_reset();
    test_default();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
